sr_input_ctrl: RTL and testbench

Upstream driver for the SR latch. Takes two raw, asynchronous, bouncy push-button inputs (set and reset), synchronises and debounces each, and converts their rising edges into clean, mutually exclusive, fixed-width `s`/`r` pulses.

The forbidden `s=r=1` combination is never presented to the latch. Simultaneous requests resolve to reset.

---
 rtl/sr_ctrl_pkg.sv | 21 ++
 rtl/sr_debounce.sv | 54 +++++
 rtl/sr_input_ctrl.sv | 121 ++++++++++++
 tb/tb_sr_input_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// ============================================================================
// sr_ctrl_pkg : FSM state encoding and counter widths for sr_input_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } sr_state_t;

  localparam int C_PULSE_W_MAX = 15;
  localparam int C_PCNT_W      = $clog2(C_PULSE_W_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/sr_debounce.sv
// ============================================================================
// sr_debounce : two-flop synchroniser, debounce counter, rising-edge request
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_debounce #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic req
);

  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_req;
  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_req    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_req   <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        // Only a 0->1 flip of the stable level is a request.
        r_stable <= ~r_stable;
        r_req    <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign req = r_req;

endmodule

`default_nettype wire

// File: rtl/sr_input_ctrl.sv
// ============================================================================
// sr_input_ctrl : debounced set/reset buttons to exclusive fixed-width s/r pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_input_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4,
  parameter int PULSE_W      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic reset_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic [C_PCNT_W-1:0] C_PCNT_LAST = C_PCNT_W'(PULSE_W - 1);
  localparam logic [C_PCNT_W-1:0] C_PCNT_ONE  = C_PCNT_W'(1);

  logic w_req_set;
  logic w_req_rst;
  logic w_want_set;
  logic w_want_rst;

  sr_state_t           r_state;
  logic [C_PCNT_W-1:0] r_pcnt;
  logic                r_pend_set;
  logic                r_pend_rst;
  logic                r_s;
  logic                r_r;
  logic                r_busy;
  logic                r_conflict;

  sr_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (set_in),
    .req   (w_req_set)
  );

  sr_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (reset_in),
    .req   (w_req_rst)
  );

  assign w_want_set = r_pend_set | w_req_set;
  assign w_want_rst = r_pend_rst | w_req_rst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_set <= 1'b0;
      r_pend_rst <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      case (r_state)
        IDLE: begin
          r_pcnt <= '0;
          if (w_want_rst) begin
            // Reset wins; a coinciding set is dropped, not queued.
            r_state    <= RST_P;
            r_r        <= 1'b1;
            r_busy     <= 1'b1;
            r_pend_rst <= 1'b0;
            r_pend_set <= 1'b0;
            r_conflict <= w_want_set;
          end else if (w_want_set) begin
            r_state    <= SET_P;
            r_s        <= 1'b1;
            r_busy     <= 1'b1;
            r_pend_set <= 1'b0;
          end
        end
        SET_P, RST_P: begin
          r_pend_set <= w_want_set;
          r_pend_rst <= w_want_rst;
          if (r_pcnt == C_PCNT_LAST) begin
            r_state <= GAP;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + C_PCNT_ONE;
          end
        end
        GAP: begin
          r_pend_set <= w_want_set;
          r_pend_rst <= w_want_rst;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_sr_input_ctrl.sv
// ============================================================================
// tb_sr_input_ctrl : directed stimulus, schedule-based reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sr_input_ctrl;

  localparam int DB = 4;
  localparam int PW = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic set_in   = 1'b0;
  logic reset_in = 1'b0;
  logic s, r, busy, conflict;

  sr_input_ctrl #(.DEBOUNCE_CNT(DB), .PULSE_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_in   (set_in),
    .reset_in (reset_in),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: per channel, raw samples two edges old feed a run-length debouncer;
  // requests join a pending set and pulses are scheduled on a timeline.
  logic rin[2], raw1[2], raw2[2], stab[2], rose[2], pend[2];
  int   run[2];
  int   free_at, p_start;
  logic p_valid, p_is_rst, p_conf;
  logic m_s = 1'b0, m_r = 1'b0, m_busy = 1'b0, m_conf = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rin[0] = set_in;
    rin[1] = reset_in;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        raw1[c] = 1'b0; raw2[c] = 1'b0; stab[c] = 1'b0;
        rose[c] = 1'b0; pend[c] = 1'b0; run[c]  = 0;
      end
      p_valid = 1'b0;
      free_at = cyc + 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        pend[c] = pend[c] | rose[c];
        rose[c] = 1'b0;
        if (raw2[c] != stab[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == DB) begin
            stab[c] = ~stab[c];
            run[c]  = 0;
            rose[c] = stab[c];
          end
        end else begin
          run[c] = 0;
        end
        raw2[c] = raw1[c];
        raw1[c] = rin[c];
      end
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        p_valid  = 1'b1;
        p_start  = cyc;
        p_is_rst = pend[1];
        p_conf   = pend[0] && pend[1];
        pend[0]  = 1'b0;
        pend[1]  = 1'b0;
        free_at  = cyc + PW + 2;
      end
    end
    m_s    = p_valid && !p_is_rst && (cyc - p_start) < PW;
    m_r    = p_valid &&  p_is_rst && (cyc - p_start) < PW;
    m_busy = p_valid && (cyc - p_start) <= PW;
    m_conf = p_valid && p_conf && (cyc == p_start);
  end

  int t0 = 0;
  int s_cnt = 0, r_cnt = 0, b_cnt = 0, c_cnt = 0;
  int first_s = -1, first_r = -1;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("s", s, m_s);
      chk("r", r, m_r);
      chk("busy", busy, m_busy);
      chk("conflict", conflict, m_conf);
      chk("s_and_r", s & r, 1'b0);
      if (cyc > t0) begin
        if (s === 1'b1) begin s_cnt++; if (first_s < 0) first_s = cyc - t0; end
        if (r === 1'b1) begin r_cnt++; if (first_r < 0) first_r = cyc - t0; end
        if (busy === 1'b1) b_cnt++;
        if (conflict === 1'b1) c_cnt++;
      end
    end
  end

  task automatic open_win();
    t0 = cyc;
    s_cnt = 0; r_cnt = 0; b_cnt = 0; c_cnt = 0;
    first_s = -1; first_r = -1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic queued(input int dly, input int exp_first_s);
    open_win();
    reset_in = 1'b1;
    wait_neg(dly);
    set_in = 1'b1;
    wait_neg(25 - dly);
    set_in   = 1'b0;
    reset_in = 1'b0;
    wait_neg(15);
    chk_int("queued_r_cnt", r_cnt, 2);
    chk_int("queued_s_cnt", s_cnt, 2);
    chk_int("queued_conflict_cnt", c_cnt, 0);
    chk_int("queued_first_r", first_r, 7);
    chk_int("queued_first_s", first_s, exp_first_s);
  endtask

  initial begin
    rst_n = 1'b0;
    wait_neg(3);
    chk("reset_s", s, 1'b0);
    chk("reset_r", r, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_conflict", conflict, 1'b0);
    rst_n = 1'b1;
    wait_neg(5);

    // Clean set: pulse starts at edge 7, lasts 2, busy 3.
    open_win();
    set_in = 1'b1;
    wait_neg(20);
    set_in = 1'b0;
    wait_neg(15);
    chk_int("clean_first_s", first_s, 7);
    chk_int("clean_s_cnt", s_cnt, 2);
    chk_int("clean_r_cnt", r_cnt, 0);
    chk_int("clean_busy_cnt", b_cnt, 3);

    // Bounce: high 1, low 2, never reaches the debounce count.
    open_win();
    repeat (10) begin
      set_in = 1'b1;
      wait_neg(1);
      set_in = 1'b0;
      wait_neg(2);
    end
    wait_neg(10);
    chk_int("bounce_s_cnt", s_cnt, 0);
    chk_int("bounce_busy_cnt", b_cnt, 0);

    // Simultaneous: reset wins, conflict pulses once.
    open_win();
    set_in   = 1'b1;
    reset_in = 1'b1;
    wait_neg(20);
    set_in   = 1'b0;
    reset_in = 1'b0;
    wait_neg(15);
    chk_int("simul_r_cnt", r_cnt, 2);
    chk_int("simul_conflict_cnt", c_cnt, 1);
    chk_int("simul_s_cnt", s_cnt, 0);
    chk_int("simul_first_r", first_r, 7);

    // Queued set: late arrival, and arrival during RST_P.
    queued(7, 14);
    queued(2, 11);

    // Reset mid-pulse with set held through reset.
    open_win();
    set_in = 1'b1;
    wait_neg(7);
    chk("midrst_s_high", s, 1'b1);
    rst_n = 1'b0;
    wait_neg(1);
    chk("midrst_s_dropped", s, 1'b0);
    chk("midrst_busy_dropped", busy, 1'b0);
    wait_neg(1);
    rst_n = 1'b1;
    open_win();
    wait_neg(25);
    chk_int("midrst_first_s", first_s, 7);
    chk_int("midrst_s_cnt", s_cnt, 2);
    set_in = 1'b0;
    wait_neg(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
